// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: converts hazard, memory-wait and halt requests
// into per-stage stall/flush controls and a branch-redirect strobe.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 200,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             LoadUseD,
    input  logic             BranchD,
    input  logic             TakenE,
    input  logic             MemReqM,
    input  logic             MemAckM,
    input  logic             HaltD,
    input  logic             Resume,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             RedirectE,
    output logic             MemErr,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCycles
);

    typedef enum logic [2:0] {
        RUN,
        BR_WAIT,
        MEM_WAIT,
        HALTED,
        ERROR
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT = TO_W'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              mem_wait;

    // A request without an ack in the same cycle is a multi-cycle access.
    assign mem_wait = MemReqM & ~MemAckM;

    // Outputs are Mealy: decoded from the registered state and the live inputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        RedirectE = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    {StallF, StallD, StallE, StallM, FlushW} = '1;
                    state_d  = MEM_WAIT;
                    to_cnt_d = TO_W'(1);
                end else if (BranchD) begin
                    StallF  = 1'b1;
                    FlushD  = 1'b1;
                    state_d = BR_WAIT;
                end else if (LoadUseD) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end else if (HaltD) begin
                    StallF  = 1'b1;
                    FlushD  = 1'b1;
                    state_d = HALTED;
                end
            end

            BR_WAIT: begin
                RedirectE = TakenE;
                if (mem_wait) begin
                    {StallF, StallD, StallE, StallM, FlushW} = '1;
                    state_d  = MEM_WAIT;
                    to_cnt_d = TO_W'(1);
                end else begin
                    state_d = RUN;
                end
            end

            MEM_WAIT: begin
                if (MemAckM) begin
                    state_d  = RUN;
                    to_cnt_d = '0;
                end else begin
                    {StallF, StallD, StallE, StallM, FlushW} = '1;
                    if (to_cnt_q >= TIMEOUT) begin
                        state_d = ERROR;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end

            HALTED: begin
                if (Resume) begin
                    state_d = RUN;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end

            ERROR: begin
                {StallF, StallD, StallE, StallM, FlushW} = '1;
            end

            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            to_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            if (StallF && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // ERROR is left only through reset, which makes the error flag sticky.
    assign MemErr      = (state_q == ERROR);
    assign Halted      = (state_q == HALTED);
    assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs change on the falling edge and the
// Mealy outputs are sampled 1 time unit later, well away from the rising edge.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

    // Output vector order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,RedirectE,MemErr,Halted}
    localparam logic [9:0] P_IDLE = 10'b0000000000;
    localparam logic [9:0] P_LU   = 10'b1100010000;
    localparam logic [9:0] P_BR   = 10'b1000100000;
    localparam logic [9:0] P_RED  = 10'b0000000100;
    localparam logic [9:0] P_MEM  = 10'b1111001000;
    localparam logic [9:0] P_ERR  = 10'b1111001010;
    localparam logic [9:0] P_HLT  = 10'b1100010001;

    logic clk;
    logic reset;
    logic LoadUseD, BranchD, TakenE, MemReqM, MemAckM, HaltD, Resume;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, RedirectE, MemErr, Halted;
    logic [CNT_W-1:0] StallCycles;
    logic [9:0] outs;

    int n_pass  = 0;
    int n_total = 0;

    pipeline_ctrl #(
        .MEM_TIMEOUT(4),
        .TO_W       (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .LoadUseD   (LoadUseD),
        .BranchD    (BranchD),
        .TakenE     (TakenE),
        .MemReqM    (MemReqM),
        .MemAckM    (MemAckM),
        .HaltD      (HaltD),
        .Resume     (Resume),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .RedirectE  (RedirectE),
        .MemErr     (MemErr),
        .Halted     (Halted),
        .StallCycles(StallCycles)
    );

    assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, RedirectE, MemErr, Halted};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply one cycle of inputs at the falling edge, then settle before sampling.
    task automatic step(input logic lu, input logic br, input logic tk, input logic mr,
                        input logic ma, input logic hd, input logic rs);
        @(negedge clk);
        LoadUseD = lu;
        BranchD  = br;
        TakenE   = tk;
        MemReqM  = mr;
        MemAckM  = ma;
        HaltD    = hd;
        Resume   = rs;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {LoadUseD, BranchD, TakenE, MemReqM, MemAckM, HaltD, Resume} = '0;
        #1 reset = 1'b1;
        #1;
        check("reset_outs", 32'(outs), 32'(P_IDLE));
        check("reset_cnt", 32'(StallCycles), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Load-use: one-cycle stall of F/D with an E bubble
        step(1, 0, 0, 0, 0, 0, 0);
        check("lu_stall", 32'(outs), 32'(P_LU));
        step(0, 0, 0, 0, 0, 0, 0);
        check("lu_after", 32'(outs), 32'(P_IDLE));
        check("lu_cnt", 32'(StallCycles), 32'd1);

        // Taken branch
        step(0, 1, 0, 0, 0, 0, 0);
        check("br_t", 32'(outs), 32'(P_BR));
        step(0, 0, 1, 0, 0, 0, 0);
        check("br_taken_redirect", 32'(outs), 32'(P_RED));
        step(0, 0, 0, 0, 0, 0, 0);
        check("br_back_run", 32'(outs), 32'(P_IDLE));
        check("br_cnt", 32'(StallCycles), 32'd2);

        // Not-taken branch
        step(0, 1, 0, 0, 0, 0, 0);
        check("brn_t", 32'(outs), 32'(P_BR));
        step(0, 0, 0, 0, 0, 0, 0);
        check("brn_no_redirect", 32'(outs), 32'(P_IDLE));

        // Memory wait: three cycles without ack, then ack
        step(0, 0, 0, 1, 0, 0, 0);
        check("mw_1", 32'(outs), 32'(P_MEM));
        step(0, 0, 0, 1, 0, 0, 0);
        check("mw_2", 32'(outs), 32'(P_MEM));
        step(0, 0, 0, 1, 0, 0, 0);
        check("mw_3", 32'(outs), 32'(P_MEM));
        step(0, 0, 0, 1, 1, 0, 0);
        check("mw_ack", 32'(outs), 32'(P_IDLE));
        step(0, 0, 0, 0, 0, 0, 0);
        check("mw_run", 32'(outs), 32'(P_IDLE));
        check("mw_cnt", 32'(StallCycles), 32'd6);

        // Single-cycle access: request and ack together
        step(0, 0, 0, 1, 1, 0, 0);
        check("mem_single", 32'(outs), 32'(P_IDLE));

        // Priority: memory wait masks branch and load-use
        step(1, 1, 0, 1, 0, 0, 0);
        check("prio_mem", 32'(outs), 32'(P_MEM));
        step(1, 1, 0, 1, 0, 0, 0);
        check("prio_mem_wait", 32'(outs), 32'(P_MEM));
        step(1, 1, 0, 1, 1, 0, 0);
        check("prio_ack", 32'(outs), 32'(P_IDLE));
        step(1, 1, 0, 0, 0, 0, 0);
        check("prio_branch_masks_lu", 32'(outs), 32'(P_BR));
        step(0, 0, 1, 0, 0, 0, 0);
        check("prio_redirect", 32'(outs), 32'(P_RED));
        check("prio_cnt", 32'(StallCycles), 32'd9);

        // Timeout: RUN entry cycle, then four MEM_WAIT cycles, then ERROR
        step(0, 0, 0, 1, 0, 0, 0);
        check("to_entry", 32'(outs), 32'(P_MEM));
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0, 0, 0);
            check("to_wait", 32'(outs), 32'(P_MEM));
        end
        step(0, 0, 0, 1, 1, 0, 0);
        check("to_err_late_ack", 32'(outs), 32'(P_ERR));
        step(0, 0, 0, 0, 0, 0, 0);
        check("to_err_sticky", 32'(outs), 32'(P_ERR));
        check("to_cnt_sat", 32'(StallCycles), 32'd15);
        step(0, 0, 0, 0, 0, 0, 0);
        check("to_cnt_hold", 32'(StallCycles), 32'd15);

        // Reset clears ERROR and the counter immediately
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_err_outs", 32'(outs), 32'(P_IDLE));
        check("rst_err_cnt", 32'(StallCycles), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Halt, with decode requests ignored while halted
        step(0, 0, 0, 0, 0, 1, 0);
        check("halt_enter", 32'(outs), 32'(P_BR));
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0, 0, 1, 0);
            check("halt_hold", 32'(outs), 32'(P_HLT));
        end
        check("halt_cnt_sat", 32'(StallCycles), 32'd15);
        step(0, 0, 0, 0, 0, 0, 1);
        check("resume_outs", 32'(outs[9:2]), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("resume_run", 32'(outs), 32'(P_IDLE));

        // Reset asserted mid-halt
        step(0, 0, 0, 0, 0, 1, 0);
        check("halt2_enter", 32'(outs), 32'(P_BR));
        step(0, 0, 0, 0, 0, 0, 0);
        check("halt2_hold", 32'(outs), 32'(P_HLT));
        #2 reset = 1'b1;
        #1;
        check("rst_halt_outs", 32'(outs), 32'(P_IDLE));
        check("rst_halt_cnt", 32'(StallCycles), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);
        check("final_idle", 32'(outs), 32'(P_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencing controller for the 5-stage pipeline. It turns the hazard unit's load-use and branch indications, data-memory wait handshakes and halt requests into per-stage stall/flush controls plus a branch-redirect strobe. It sits beside the hazard unit and drives the enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
MEM_TIMEOUT, 200, cycles in MEM_WAIT before entering ERROR (must be >=1, < 2**TO_W)
TO_W, 8, width of timeout counter
CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
LoadUseD  in  1  load-use hazard detected for instruction in decode
BranchD  in  1  branch/jump/loop instruction in decode
TakenE  in  1  branch outcome, valid in cycle after BranchD accepted
MemReqM  in  1  memory-stage instruction accesses data memory
MemAckM  in  1  data memory completes access this cycle
HaltD  in  1  halt instruction in decode
Resume  in  1  leave HALTED
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushD  out  1  bubble into IF/ID
FlushE  out  1  bubble into ID/EX
FlushW  out  1  bubble into MEM/WB
RedirectE  out  1  select branch target for PC
MemErr  out  1  sticky memory timeout error
Halted  out  1  state==HALTED
StallCycles  out  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- States: RUN, BR_WAIT, MEM_WAIT, HALTED, ERROR. Registered state; outputs are Mealy-decoded from state and current inputs (same-cycle effect).
- Reset (async): state=RUN, timeout counter=0, StallCycles=0, MemErr=0. All stall/flush/Redirect outputs are 0 in RUN with idle inputs.
- RUN priority, highest first:
  1. MemReqM & !MemAckM: StallF=StallD=StallE=StallM=1, FlushW=1; next MEM_WAIT, counter=1.
  2. BranchD: StallF=1, FlushD=1; next BR_WAIT.
  3. LoadUseD: StallF=StallD=1, FlushE=1; stay RUN for a single cycle. The hazard unit clears the request once the load advances.
  4. HaltD: StallF=1, FlushD=1; next HALTED.
  5. Otherwise all 0.
- MemReqM & MemAckM in the same cycle is a single-cycle access: no stall.
- BR_WAIT: RedirectE=TakenE; no stalls; next RUN. If MemReqM & !MemAckM occurs here, apply the MEM_WAIT stall set and go to MEM_WAIT. Only the branch redirect is captured (RedirectE this cycle); the branch in EX is held by StallE.
- MEM_WAIT: StallF=StallD=StallE=StallM=1, FlushW=1 while !MemAckM; counter increments each cycle.
  - MemAckM=1: all outputs 0 and next RUN. The held D-stage instruction is re-evaluated then.
  - Counter reaching MEM_TIMEOUT without ack: next ERROR.
- HALTED: StallF=StallD=1, FlushE=1, Halted=1. Resume=1 gives next RUN with outputs 0 in the resume cycle. Other inputs are ignored.
- ERROR: StallF/D/E/M=1, FlushW=1, MemErr=1. Exit only by reset; late MemAckM is ignored.
- Simultaneous events: a memory wait masks branch, load-use and halt. A branch masks load-use and halt. Lower-priority requests persist because D is held.
- StallCycles: +1 each clock where StallF=1. Saturates at all-ones with no wrap.
- Reset mid-operation: takes effect immediately regardless of state; outputs drop to RUN defaults.

Test Plan:
- Load-use: LoadUseD=1 for one cycle in RUN -> that cycle StallF=StallD=FlushE=1, next cycle all 0, StallCycles=1.
- Taken branch: BranchD=1 at cycle t, TakenE=1 at t+1 -> t: StallF=FlushD=1; t+1: RedirectE=1, state RUN at t+2. With TakenE=0 -> RedirectE=0.
- Memory wait: MemReqM=1, MemAckM low 3 cycles then high -> 3 cycles of StallF..StallM=FlushW=1, ack cycle all 0; MemReqM&MemAckM together -> no stall.
- Priority: MemReqM=1, MemAckM=0, BranchD=1, LoadUseD=1 same cycle -> MEM_WAIT only, FlushD=0; after ack, BranchD still high -> branch sequence runs.
- Timeout: MEM_TIMEOUT=4, no ack -> ERROR after 4 MEM_WAIT cycles, MemErr=1 sticky; late ack has no effect; reset clears it.
- Halt/saturation: HaltD -> Halted=1 until Resume. With CNT_W=4, 20 halted cycles -> StallCycles=15. Asserting reset mid-halt -> Halted=0 and StallCycles=0 immediately.
